// File: rtl/jk_bank_controller.sv
// Command sequencer for a bank of W external JK flip-flops.
// Turns SET/CLEAR/TOGGLE/LOAD/COUNT commands into registered J/K drive
// vectors, keeps a shadow copy of the bank state and flags readback errors.
module jk_bank_controller #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [2:0]    CMD_OP,
    input  logic [W-1:0]  CMD_DATA,
    input  logic [CW-1:0] CMD_COUNT,
    input  logic          ERR_CLR,
    output logic [W-1:0]  J,
    output logic [W-1:0]  K,
    input  logic [W-1:0]  Q,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_COUNT  = 3'd5;

    logic [1:0]    state;
    logic [W-1:0]  shadow;
    logic [W-1:0]  shadow_next;
    logic [W-1:0]  cnt_vec;
    logic [W-1:0]  acc_j;
    logic [W-1:0]  acc_k;
    logic [CW-1:0] steps;
    logic          accept;
    logic          reserved;
    logic          mismatch;
    logic          err_set;

    assign CMD_READY = (state == S_IDLE) && !RESET;
    assign BUSY      = (state != S_IDLE);
    assign accept    = CMD_VALID && CMD_READY;
    assign reserved  = CMD_OP[2] & CMD_OP[1];
    assign mismatch  = (Q != shadow);
    assign err_set   = (accept && reserved) || ((state == S_CHECK) && mismatch);

    // Increment drive: bit i toggles when all lower shadow bits are one.
    always_comb begin
        logic carry;
        cnt_vec = '0;
        carry   = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_vec[i] = carry;
            carry      = carry & shadow[i];
        end
    end

    // First-step J/K drive for the command being accepted.
    always_comb begin
        acc_j = '0;
        acc_k = '0;
        case (CMD_OP)
            OP_SET:    acc_j = '1;
            OP_CLEAR:  acc_k = '1;
            OP_TOGGLE: begin
                acc_j = CMD_DATA;
                acc_k = CMD_DATA;
            end
            OP_LOAD: begin
                acc_j = CMD_DATA;
                acc_k = ~CMD_DATA;
            end
            OP_COUNT: begin
                if (CMD_COUNT != '0) begin
                    acc_j = cnt_vec;
                    acc_k = cnt_vec;
                end
            end
            default: begin
                acc_j = '0;
                acc_k = '0;
            end
        endcase
    end

    // Shadow state after applying the current J/K drive with JK rules.
    always_comb begin
        shadow_next = shadow;
        for (int unsigned i = 0; i < W; i++) begin
            case ({J[i], K[i]})
                2'b10:   shadow_next[i] = 1'b1;
                2'b01:   shadow_next[i] = 1'b0;
                2'b11:   shadow_next[i] = ~shadow[i];
                default: shadow_next[i] = shadow[i];
            endcase
        end
    end

    // Sequencer: state, registered drive, shadow, remaining steps, DONE pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            J      <= '0;
            K      <= '0;
            shadow <= '0;
            steps  <= '0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (reserved) begin
                            DONE <= 1'b1;
                        end else begin
                            state <= S_DRIVE;
                            J     <= acc_j;
                            K     <= acc_k;
                            if ((CMD_OP == OP_COUNT) && (CMD_COUNT != '0))
                                steps <= CMD_COUNT - CW'(1);
                            else
                                steps <= '0;
                        end
                    end
                end
                S_DRIVE: begin
                    shadow <= shadow_next;
                    J      <= '0;
                    K      <= '0;
                    state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    state <= S_CHECK;
                end
                default: begin
                    if (mismatch) begin
                        // Resynchronise to the real bank and drop the rest.
                        shadow <= Q;
                        steps  <= '0;
                        state  <= S_IDLE;
                        DONE   <= 1'b1;
                    end else if (steps != '0) begin
                        steps <= steps - CW'(1);
                        J     <= cnt_vec;
                        K     <= cnt_vec;
                        state <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                        DONE  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky error flag; a new error event takes priority over ERR_CLR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            ERROR <= 1'b0;
        else if (err_set)
            ERROR <= 1'b1;
        else if (ERR_CLR)
            ERROR <= 1'b0;
    end

endmodule

// File: tb/tb_jk_bank_controller.sv
// Bench for jk_bank_controller: drives a behavioural JK bank, applies a
// table of directed commands, hand-written corner sequences and random
// commands checked against an arithmetic model of the bank value.
module tb_jk_bank_controller;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [2:0]    CMD_OP;
    logic [W-1:0]  CMD_DATA;
    logic [CW-1:0] CMD_COUNT;
    logic          ERR_CLR;
    logic [W-1:0]  J;
    logic [W-1:0]  K;
    logic [W-1:0]  Q;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;

    logic [W-1:0]  bank;
    logic [W-1:0]  stuck0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [7:0] cnt;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;
        int         lat;
        logic       eerr;
    } vec_t;

    vec_t tbl [11];

    jk_bank_controller #(.W(W), .CW(CW)) dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_COUNT(CMD_COUNT),
        .ERR_CLR(ERR_CLR), .J(J), .K(K), .Q(Q), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // External JK bank: Q+ = J&~Q | ~K&Q, cleared by the system reset.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) bank <= '0;
        else       bank <= (J & ~bank) | (~K & bank);
    end

    assign Q = bank & ~stuck0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of one command applied to bank value v with error e.
    function automatic vec_t model(input logic [2:0] op, input logic [3:0] d,
                                   input logic [7:0] n, input logic [3:0] v,
                                   input logic e);
        vec_t r;
        r.op = op; r.data = d; r.cnt = n;
        r.ej = 4'h0; r.ek = 4'h0; r.eq = v; r.lat = 4; r.eerr = e;
        case (op)
            3'd1: begin r.ej = 4'hF; r.eq = 4'hF; end
            3'd2: begin r.ek = 4'hF; r.eq = 4'h0; end
            3'd3: begin r.ej = d; r.ek = d; r.eq = v ^ d; end
            3'd4: begin r.ej = d; r.ek = ~d; r.eq = d; end
            3'd5: begin
                if (n != 0) begin
                    r.ej  = v ^ (v + 4'd1);
                    r.ek  = r.ej;
                    r.eq  = v + n[3:0];
                    r.lat = 3 * int'(n) + 1;
                end
            end
            3'd6, 3'd7: begin r.lat = 1; r.eerr = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    // Called at a negedge with the controller idle; returns at the DONE negedge.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [7:0] cnt,
                           output logic [3:0] dj, output logic [3:0] dk,
                           output int lat, output int busy_bad);
        check("ready_before_cmd", CMD_READY, 1);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = data; CMD_COUNT = cnt;
        @(negedge CLK);
        CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_DATA = '0; CMD_COUNT = '0;
        dj = J; dk = K; lat = 0; busy_bad = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (DONE) begin
                lat = c;
                break;
            end
            if (!BUSY) busy_bad++;
            @(negedge CLK);
        end
        if (lat == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no DONE expected DONE within 1000 cycles");
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [3:0] dj, dk;
        int lat, busy_bad;
        run_cmd(v.op, v.data, v.cnt, dj, dk, lat, busy_bad);
        check({tag, "_j"}, dj, v.ej);
        check({tag, "_k"}, dk, v.ek);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_gaps"}, busy_bad, 0);
        check({tag, "_busy_at_done"}, BUSY, 0);
        check({tag, "_q"}, Q, v.eq);
        check({tag, "_error"}, ERROR, v.eerr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mv;
        logic       merr;
        vec_t       v;

        tbl[0]  = '{3'd1, 4'h0, 8'd0,  4'hF, 4'h0, 4'hF, 4,  1'b0};
        tbl[1]  = '{3'd4, 4'hA, 8'd0,  4'hA, 4'h5, 4'hA, 4,  1'b0};
        tbl[2]  = '{3'd3, 4'h3, 8'd0,  4'h3, 4'h3, 4'h9, 4,  1'b0};
        tbl[3]  = '{3'd2, 4'h0, 8'd0,  4'h0, 4'hF, 4'h0, 4,  1'b0};
        tbl[4]  = '{3'd5, 4'h0, 8'd18, 4'h1, 4'h1, 4'h2, 55, 1'b0};
        tbl[5]  = '{3'd5, 4'h0, 8'd0,  4'h0, 4'h0, 4'h2, 4,  1'b0};
        tbl[6]  = '{3'd0, 4'h7, 8'd0,  4'h0, 4'h0, 4'h2, 4,  1'b0};
        tbl[7]  = '{3'd6, 4'hF, 8'd3,  4'h0, 4'h0, 4'h2, 1,  1'b1};
        tbl[8]  = '{3'd7, 4'hF, 8'd3,  4'h0, 4'h0, 4'h2, 1,  1'b1};
        tbl[9]  = '{3'd5, 4'h0, 8'd1,  4'h1, 4'h1, 4'h3, 4,  1'b1};
        tbl[10] = '{3'd5, 4'h0, 8'd5,  4'h7, 4'h7, 4'h8, 16, 1'b1};

        RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_DATA = '0;
        CMD_COUNT = '0; ERR_CLR = 1'b0; stuck0 = '0;
        #2;
        check("rst_j", J, 0);
        check("rst_k", K, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_error", ERROR, 0);
        check("rst_ready", CMD_READY, 0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", CMD_READY, 1);

        // Directed table, every command issued in the previous DONE cycle.
        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // ERR_CLR alone clears the sticky flag.
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("errclr_clears", ERROR, 0);

        // A reserved opcode coinciding with ERR_CLR keeps ERROR set.
        CMD_VALID = 1'b1; CMD_OP = 3'd6; ERR_CLR = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0; CMD_OP = 3'd0; ERR_CLR = 1'b0;
        check("set_wins_error", ERROR, 1);
        check("set_wins_done", DONE, 1);
        check("set_wins_busy", BUSY, 0);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("errclr_again", ERROR, 0);

        // Q bit 2 stuck low during COUNT 8 from zero: abort at the 3->4 check.
        apply(model(3'd2, 4'h0, 8'd0, 4'h2, 1'b0), "pre_stuck_clear");
        stuck0 = 4'h4;
        v = '{3'd5, 4'h0, 8'd8, 4'h1, 4'h1, 4'h0, 13, 1'b1};
        apply(v, "stuck_count");
        // Shadow now equals Q (0), so the next increment drives only bit 0.
        v = '{3'd5, 4'h0, 8'd1, 4'h1, 4'h1, 4'h1, 4, 1'b1};
        apply(v, "after_stuck");
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("stuck_errclr", ERROR, 0);

        // Reset during the DRIVE cycle of a COUNT (shadow is 1 here).
        CMD_VALID = 1'b1; CMD_OP = 3'd5; CMD_COUNT = 8'd5;
        @(negedge CLK);
        CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_COUNT = '0;
        check("midrst_drive_j", J, 4'h3);
        RESET = 1'b1;
        #1;
        check("midrst_j", J, 0);
        check("midrst_k", K, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_ready", CMD_READY, 0);
        stuck0 = '0;
        begin
            int done_seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                if (DONE) done_seen++;
            end
            RESET = 1'b0;
            @(negedge CLK);
            if (DONE) done_seen++;
            check("midrst_no_done", done_seen, 0);
        end
        check("midrst_ready_after", CMD_READY, 1);
        apply(model(3'd5, 4'h0, 8'd1, 4'h0, 1'b0), "midrst_shadow_zero");

        // Random commands against the arithmetic model.
        mv = 4'h1; merr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 6));
            v = model(op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 20)), mv, merr);
            apply(v, $sformatf("rnd%0d", i));
            mv = v.eq;
            merr = v.eerr;
            if (merr && ($urandom_range(0, 2) == 0)) begin
                ERR_CLR = 1'b1;
                @(negedge CLK);
                ERR_CLR = 1'b0;
                check("rnd_errclr", ERROR, 0);
                merr = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_controller.md
Name: jk_bank_controller

Overview:
- Command-driven sequencer for a bank of W external JK flip-flops (the JKFFasync cells) sharing CLK.
- Translates high-level operations (set, clear, toggle mask, load value, count up N steps) into per-cycle J/K drive vectors.
- Reads back the bank's Q outputs and checks them against an internal shadow model; flags any mismatch.

Parameters:
- W, 4, number of JK flip-flops in the controlled bank.
- CW, 8, width of the step-count field for COUNT commands.

Ports:
- CLK  input  1  rising-edge clock, shared with the JK bank.
- RESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  controller can accept a command (combinational: state==IDLE and RESET low).
- CMD_OP  input  3  0 NOP, 1 SET, 2 CLEAR, 3 TOGGLE, 4 LOAD, 5 COUNT, 6/7 reserved.
- CMD_DATA  input  W  toggle mask (TOGGLE) or load value (LOAD).
- CMD_COUNT  input  CW  number of count steps (COUNT only).
- ERR_CLR  input  1  clears sticky ERROR.
- J  output  W  J drive to bank, registered.
- K  output  W  K drive to bank, registered.
- Q  input  W  bank outputs.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when a command completes.
- ERROR  output  1  sticky: readback mismatch or reserved opcode.

Behaviour:
- Reset (async): state=IDLE, J=K=0, shadow=0, step counter=0, BUSY=0, DONE=0, ERROR=0.
  - The bank is cleared by the same system reset, so shadow=0 matches it.
  - CMD_READY is low while RESET is high.
  - Reset mid-command aborts the command immediately; no DONE is produced.
- Handshake:
  - A command is accepted on a rising edge where CMD_VALID & CMD_READY.
  - CMD_OP, CMD_DATA and CMD_COUNT are captured at that edge; inputs are ignored while BUSY.
- States: IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | IDLE).
- IDLE:
  - J=K=0.
  - On accept: reserved opcode sets ERROR, stays in IDLE, and pulses DONE next cycle. Any other opcode goes to DRIVE.
- DRIVE (exactly one cycle; the bank updates at the edge that ends it):
  - NOP: J=0, K=0.
  - SET: J=all 1, K=0.
  - CLEAR: J=0, K=all 1.
  - TOGGLE: J=K=CMD_DATA.
  - LOAD: J=CMD_DATA, K=~CMD_DATA.
  - COUNT step: J[i]=K[i]=AND of shadow[i-1:0], with bit 0 always 1.
  - Shadow updates at the edge leaving DRIVE using JK rules on the driven vectors.
  - COUNT wraps: all ones -> 0.
- SETTLE: J=K=0 (hold); one cycle.
- CHECK: J=K=0; compares Q with shadow.
  - Mismatch: set ERROR, load shadow<=Q, abort remaining steps, go to IDLE.
  - Match and remaining steps>0: decrement and go to DRIVE.
  - Otherwise go to IDLE.
- COUNT with CMD_COUNT=0: DRIVE drives J=K=0 (NOP step); one check only.
- Latency:
  - Single-step ops: accept edge + 3 cycles (DRIVE, SETTLE, CHECK); DONE is high in the first IDLE cycle after.
  - COUNT N (N>=1): 3N cycles, then DONE.
- Back-to-back: CMD_READY is high during the DONE cycle, so a new command may be accepted there.
- ERROR clearing:
  - ERR_CLR clears ERROR on the next edge.
  - If ERR_CLR coincides with a new error event, ERROR stays set (the set wins).
  - ERROR does not block new commands.

Test Plan:
- Reset then SET (W=4) -> J=4'hF, K=0 for one cycle; Q=4'hF at CHECK; DONE pulses at accept+4 cycles; ERROR=0.
- LOAD CMD_DATA=4'hA then TOGGLE CMD_DATA=4'h3 -> after LOAD, Q=4'hA; after TOGGLE, Q=4'h9; both back-to-back using the DONE-cycle accept.
- CLEAR then COUNT CMD_COUNT=18 -> Q sequence 1,2,…,15,0,1,2; final Q=4'h2; DONE after 54 cycles; BUSY high throughout.
- Force the bank Q bit 2 stuck at 0 during COUNT 8 from 0 -> ERROR sets at the CHECK after Q should reach 4; command aborts; DONE pulses; shadow=Q. Then ERR_CLR -> ERROR=0.
- Reserved opcode 6 -> no J/K activity; ERROR=1; DONE pulse next cycle; BUSY stays 0.
- Assert RESET mid-COUNT (during DRIVE) -> J=K=0, BUSY=0, CMD_READY=0 immediately; no DONE. After release, CMD_READY=1 and shadow=0.
